// File: rtl/led_sink_pwm_sched_if.sv
// Duty-table write port for the LED sink PWM scheduler.
// master drives wr_en/wr_addr/wr_data, slave (the scheduler) samples them.
interface led_sink_pwm_sched_if #(
    parameter int DUTY_W = 8
);
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DUTY_W-1:0] wr_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_data
    );
endinterface

// File: rtl/led_sink_pwm_sched.sv
// LED sink frame scheduler: per-frame PWM tick counter driving N_SINK sinks
// from a double-buffered duty table, restarted by the sync head.
// Ports: clk, i_RESET (sync, active-high), i_SYNC_EDGE, i_HEAD_FLAG,
//   wr (duty write port, slave), o_LED_SINK, o_FRAME_PULSE, o_TICK, o_SYNC_LOST.
// Option: define LED_SCHED_WDOG_EN to enable the sync-loss watchdog.
module led_sink_pwm_sched #(
    parameter int N_SINK   = 32,
    parameter int DUTY_W   = 8,
    parameter int WDOG_CYC = 64
) (
    input  logic                clk,
    input  logic                i_RESET,
    input  logic                i_SYNC_EDGE,
    input  logic                i_HEAD_FLAG,
    led_sink_pwm_sched_if.slave wr,
    output logic [N_SINK-1:0]   o_LED_SINK,
    output logic                o_FRAME_PULSE,
    output logic [DUTY_W-1:0]   o_TICK,
    output logic                o_SYNC_LOST
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    localparam logic [DUTY_W-1:0] TICK_MAX = '1;

    state_t            state, state_n;
    logic [DUTY_W-1:0] tick, tick_n;
    logic              pulse_n;
    logic              load;
    logic              head;
    logic              timeout;

    logic [DUTY_W-1:0] shadow   [N_SINK];
    logic [DUTY_W-1:0] duty_act [N_SINK];

    assign head = i_SYNC_EDGE & i_HEAD_FLAG;

`ifdef LED_SCHED_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            lost;

    // Fires once, on the clk where the quiet count reaches WDOG_CYC.
    assign timeout = !i_SYNC_EDGE && (wd_cnt == WD_W'(WDOG_CYC - 1));

    always_ff @(posedge clk) begin
        if (i_RESET) begin
            wd_cnt <= '0;
            lost   <= 1'b0;
        end else begin
            if (i_SYNC_EDGE)
                wd_cnt <= '0;
            else if (wd_cnt != WD_W'(WDOG_CYC))
                wd_cnt <= wd_cnt + 1'b1;
            if (head)
                lost <= 1'b0;
            else if (timeout)
                lost <= 1'b1;
        end
    end

    assign o_SYNC_LOST = lost;
`else
    assign timeout     = 1'b0;
    assign o_SYNC_LOST = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_RESET) begin
            state <= IDLE;
            tick  <= '0;
        end else begin
            state <= state_n;
            tick  <= tick_n;
        end
    end

    // Head has priority: it restarts the frame from any state.
    always_comb begin
        state_n = state;
        tick_n  = tick;
        pulse_n = 1'b0;
        load    = 1'b0;
        if (head) begin
            state_n = RUN;
            tick_n  = '0;
            pulse_n = 1'b1;
            load    = 1'b1;
        end else if (timeout) begin
            state_n = IDLE;
            tick_n  = '0;
        end else if (i_SYNC_EDGE && state == RUN) begin
            if (tick == TICK_MAX)
                state_n = HOLD;
            else
                tick_n = tick + 1'b1;
        end
    end

    // Shadow write and head copy in the same clk: the copy sees the old shadow.
    always_ff @(posedge clk) begin
        if (i_RESET) begin
            for (int k = 0; k < N_SINK; k++) begin
                shadow[k]   <= '0;
                duty_act[k] <= '0;
            end
        end else begin
            if (load)
                duty_act <= shadow;
            if (wr.wr_en && (int'(wr.wr_addr) < N_SINK))
                shadow[wr.wr_addr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_RESET || timeout) begin
            o_LED_SINK <= '0;
        end else begin
            for (int k = 0; k < N_SINK; k++)
                o_LED_SINK[k] <= (state == RUN) && (tick < duty_act[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (i_RESET)
            o_FRAME_PULSE <= 1'b0;
        else
            o_FRAME_PULSE <= pulse_n;
    end

    assign o_TICK = tick;

endmodule
